// File: rtl/lc3_pipe_controller.sv
// rtl/lc3_pipe_controller.sv - stage enables, memory FSM, bypass and branch control for the LC-3 pipeline
//
// Purpose: sequences fetch/decode/execute/memaccess/writeback, stalling the
// whole pipe while a data-memory operation is outstanding and the front end
// for BR_BUBBLES cycles after a BR/JMP is decoded.
//
// Ports:
//   clock_i, reset_i            clock, asynchronous active-high reset
//   IR, IR_Exec                 instructions in decode and execute
//   psr                         NZP flags used to resolve BR
//   complete_data               data-memory access finished this cycle
//   complete_instr              instruction fetch valid this cycle
//   enable_*                    per-stage enables (registered, then gated)
//   mem_state                   0=READ 1=INDIRECT 2=WRITE 3=IDLE
//   br_taken                    redirect from the instruction in execute
//   bypass_alu_1/2, bypass_mem_1/2  operand forwarding selects
//   stall_cycles                (LC3_CTRL_PERF_EN only) saturating count of
//                               cycles with enable_fetch low
//
// Optional feature macro: LC3_CTRL_PERF_EN

module lc3_pipe_controller #(
  parameter int BR_BUBBLES = 3,
  parameter int CNT_W      = 3
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  input  logic        complete_data,
  input  logic        complete_instr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic [1:0]  mem_state,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2
`ifdef LC3_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam logic [1:0] MEM_READ     = 2'd0;
  localparam logic [1:0] MEM_INDIRECT = 2'd1;
  localparam logic [1:0] MEM_WRITE    = 2'd2;
  localparam logic [1:0] MEM_IDLE     = 2'd3;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [3:0]       op_d, op_x;
  logic [1:0]       state_q, state_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic             exec_fresh;
  logic             ind_store_q;   // INDIRECT was entered by STI, so it finishes in WRITE
  logic             back_q;        // decode/execute may run: memory idle, out of reset
  logic             front_q;       // fetch/PC may run: additionally no branch bubble
  logic             alu_x, load_x, src1_user, src2_user, match_1, match_2, read_done;
  logic             unused_ir_bits;

  assign op_d = IR[15:12];
  assign op_x = IR_Exec[15:12];
  assign unused_ir_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

  assign alu_x     = (op_x == OP_ADD) || (op_x == OP_AND) || (op_x == OP_NOT);
  assign load_x    = (op_x == OP_LD) || (op_x == OP_LDR) || (op_x == OP_LDI);
  assign src1_user = (op_d == OP_ADD) || (op_d == OP_AND) || (op_d == OP_NOT) ||
                     (op_d == OP_LDR) || (op_d == OP_STR);
  assign src2_user = ((op_d == OP_ADD) || (op_d == OP_AND)) && !IR[5];
  assign match_1   = (IR_Exec[11:9] == IR[8:6]);
  assign match_2   = (IR_Exec[11:9] == IR[2:0]);
  assign read_done = (state_q == MEM_READ) && complete_data;

  // State register: FSM, bubble counter and the enables, which are derived
  // from next-state values so a stall shows up the cycle after its cause.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= MEM_IDLE;
      cnt_q       <= '0;
      exec_fresh  <= 1'b0;
      ind_store_q <= 1'b0;
      back_q      <= 1'b0;
      front_q     <= 1'b0;
    end else begin
      state_q    <= state_next;
      cnt_q      <= cnt_next;
      exec_fresh <= enable_execute;
      if (state_q == MEM_IDLE && state_next == MEM_INDIRECT)
        ind_store_q <= (op_x == OP_STI);
      back_q  <= (state_next == MEM_IDLE);
      front_q <= (state_next == MEM_IDLE) && (cnt_next == '0);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_q;
    case (state_q)
      MEM_IDLE: begin
        if (exec_fresh) begin
          case (op_x)
            OP_LD, OP_LDR:  state_next = MEM_READ;
            OP_LDI, OP_STI: state_next = MEM_INDIRECT;
            OP_ST, OP_STR:  state_next = MEM_WRITE;
            default:        state_next = MEM_IDLE;
          endcase
        end
      end
      MEM_INDIRECT: if (complete_data) state_next = ind_store_q ? MEM_WRITE : MEM_READ;
      default:      if (complete_data) state_next = MEM_IDLE;
    endcase

    // A newly decoded BR/JMP reloads the bubble count; the count freezes
    // while memory is busy so bubbles are not absorbed by the memory stall.
    cnt_next = cnt_q;
    if (enable_decode && (op_d == OP_BR || op_d == OP_JMP))
      cnt_next = CNT_W'(BR_BUBBLES);
    else if (state_q == MEM_IDLE && cnt_q != '0)
      cnt_next = cnt_q - 1'b1;
  end

  // Output logic
  always_comb begin
    mem_state      = state_q;
    enable_execute = back_q;
    enable_decode  = back_q && complete_instr;
    enable_fetch   = front_q && complete_instr;

    br_taken = exec_fresh &&
               (((op_x == OP_BR) && ((IR_Exec[11:9] & psr) != 3'b000)) || (op_x == OP_JMP));
    // A redirect must load the PC even inside the bubble window or a fetch gap.
    enable_updatePC = back_q && (br_taken || (front_q && complete_instr));

    enable_writeback = read_done || (exec_fresh && (alu_x || (op_x == OP_LEA)));

    // Memory forwarding is qualified by the read completing rather than by
    // exec_fresh, since the load has sat in execute for the whole stall.
    bypass_mem_1 = read_done && load_x && src1_user && match_1;
    bypass_mem_2 = read_done && load_x && src2_user && match_2;
    bypass_alu_1 = exec_fresh && (alu_x || (op_x == OP_LEA)) && src1_user && match_1 && !bypass_mem_1;
    bypass_alu_2 = exec_fresh && alu_x && src2_user && match_2 && !bypass_mem_2;
  end

`ifdef LC3_CTRL_PERF_EN
  logic run_q;  // excludes the cycle in which reset is released

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      run_q        <= 1'b0;
      stall_cycles <= '0;
    end else begin
      run_q <= 1'b1;
      if (run_q && !enable_fetch && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
